// File: rtl/leglite_pkg.sv
// Shared LEGLite definitions: opcodes, instruction field positions, fetch FSM
// state encoding and the branch-offset helper.
package leglite_pkg;

    localparam logic [2:0] OPC_ADD  = 3'd0;
    localparam logic [2:0] OPC_NOP  = 3'd1;
    localparam logic [2:0] OPC_LD   = 3'd3;
    localparam logic [2:0] OPC_ST   = 3'd4;
    localparam logic [2:0] OPC_CBZ  = 3'd5;
    localparam logic [2:0] OPC_ADDI = 3'd6;
    localparam logic [2:0] OPC_ANDI = 3'd7;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 13;
    localparam int BOFF_MSB = 12;
    localparam int BOFF_LSB = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2
    } fetch_state_t;

    // Signed 7-bit word offset to a 16-bit byte offset.
    function automatic logic [15:0] boff_to_bytes(input logic [6:0] off);
        return {{8{off[6]}}, off, 1'b0};
    endfunction

endpackage

// File: rtl/leglite_next_pc.sv
// Combinational next-PC selection: taken branch adds the scaled signed offset,
// otherwise the PC advances by one 16-bit instruction.
module leglite_next_pc
    import leglite_pkg::*;
(
    input  logic [15:0] pc,
    input  logic [6:0]  boff,
    input  logic        branch,
    input  logic        zero,
    output logic [15:0] next_pc
);

    logic        w_taken;
    logic [15:0] w_sum;

    // Select branch target or sequential address; modulo-2^16 wrap is intended.
    always_comb begin
        w_taken = branch & zero;
        if (w_taken) begin
            w_sum = pc + boff_to_bytes(boff);
        end else begin
            w_sum = pc + 16'd2;
        end
        next_pc = {w_sum[15:1], 1'b0};
    end

endmodule

// File: rtl/leglite_ifetch.sv
// LEGLite instruction fetch/sequencer: owns the PC, handshakes with instruction
// memory and holds the executing instruction for control and datapath.
module leglite_ifetch
    import leglite_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [2:0]  NOP_OPCODE = 3'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [2:0]  opcode,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    output logic [15:0] pc,
    output logic [15:0] icount
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [15:0]  r_pc;
    logic [15:0]  r_instr;
    logic [15:0]  r_icount;
    logic [15:0]  w_pc_nxt;
    logic [15:0]  w_instr_nxt;
    logic [15:0]  w_icount_nxt;
    logic [15:0]  w_next_pc;

    leglite_next_pc u_next_pc (
        .pc      (r_pc),
        .boff    (r_instr[BOFF_MSB:BOFF_LSB]),
        .branch  (branch),
        .zero    (zero),
        .next_pc (w_next_pc)
    );

    // State and architectural registers; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= {RESET_PC[15:1], 1'b0};
            r_instr  <= 16'h0000;
            r_icount <= 16'h0000;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_icount <= w_icount_nxt;
        end
    end

    // Next-state logic; the request is held until acknowledged, even if run drops.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_icount_nxt = r_icount;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    w_icount_nxt = r_icount + 16'd1;
                    w_pc_nxt     = w_next_pc;
                    if (run) begin
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded only from registered state and the held instruction.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        opcode      = NOP_OPCODE;
        if (r_state == ST_REQ) begin
            imem_req = 1'b1;
        end else if (r_state == ST_EXEC) begin
            instr_valid = 1'b1;
            opcode      = r_instr[OPC_MSB:OPC_LSB];
        end else begin
            imem_req = 1'b0;
        end
        imem_addr = r_pc;
        pc        = r_pc;
        instr     = r_instr;
        icount    = r_icount;
    end

endmodule

// File: tb/tb_leglite_ifetch.sv
// Directed self-checking bench for leglite_ifetch with hand-computed expectations.
module tb_leglite_ifetch;

    logic        clock;
    logic        reset;
    logic        run;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [2:0]  opcode;
    logic [15:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [15:0] pc;
    logic [15:0] icount;

    int total = 0;
    int bad   = 0;

    leglite_ifetch dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .opcode      (opcode),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .pc          (pc),
        .icount      (icount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Fetch-side snapshot: request, address, valid, opcode.
    task automatic chk_fetch(input string tag, input logic req, input logic [15:0] addr,
                             input logic vld, input logic [2:0] opc);
        chk({tag, ".req"},  {15'd0, imem_req},    {15'd0, req});
        chk({tag, ".addr"}, imem_addr,            addr);
        chk({tag, ".vld"},  {15'd0, instr_valid}, {15'd0, vld});
        chk({tag, ".opc"},  {13'd0, opcode},      {13'd0, opc});
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
        stall = 1'b0; branch = 1'b0; zero = 1'b0;
        step(); step();
        chk_fetch("rst", 1'b0, 16'h0000, 1'b0, 3'd1);
        chk("rst.icount", icount, 16'h0000);
        chk("rst.instr",  instr,  16'h0000);

        // Same-cycle ack with ADD at address 0.
        reset = 1'b0; run = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h0000;
        step();
        chk_fetch("c1", 1'b1, 16'h0000, 1'b0, 3'd1);
        step();
        chk_fetch("c2", 1'b0, 16'h0000, 1'b1, 3'd0);
        chk("c2.icount", icount, 16'h0000);
        imem_ack = 1'b0;
        step();
        chk_fetch("c3", 1'b1, 16'h0002, 1'b0, 3'd1);
        chk("c3.icount", icount, 16'h0001);

        // Ack delayed 3 cycles; run drops during the wait without aborting.
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_fetch("wait", 1'b1, 16'h0002, 1'b0, 3'd1);
        end
        run = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hA1C0;  // CBZ +7 words
        step();
        chk_fetch("cbz7", 1'b0, 16'h0002, 1'b1, 3'd5);
        chk("cbz7.instr", instr, 16'hA1C0);
        imem_ack = 1'b0; branch = 1'b1; zero = 1'b1;
        step();
        chk_fetch("to10", 1'b1, 16'h0010, 1'b0, 3'd1);

        // CBZ -2 words at 0x0010 taken.
        imem_ack = 1'b1; imem_rdata = 16'hBF80;
        step();
        chk_fetch("cbzm2", 1'b0, 16'h0010, 1'b1, 3'd5);
        imem_ack = 1'b0;
        step();
        chk_fetch("to0C", 1'b1, 16'h000C, 1'b0, 3'd1);
        chk("to0C.icount", icount, 16'h0003);

        // Back to 0x0010 with CBZ +2, then the same CBZ -2 not taken.
        imem_ack = 1'b1; imem_rdata = 16'hA080;
        step();
        imem_ack = 1'b0;
        step();
        chk_fetch("back10", 1'b1, 16'h0010, 1'b0, 3'd1);
        imem_ack = 1'b1; imem_rdata = 16'hBF80;
        step();
        imem_ack = 1'b0; zero = 1'b0;
        step();
        chk_fetch("nt12", 1'b1, 16'h0012, 1'b0, 3'd1);
        chk("nt12.icount", icount, 16'h0005);

        // LD with a two-cycle stall.
        branch = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h6000;
        step();
        chk_fetch("ld0", 1'b0, 16'h0012, 1'b1, 3'd3);
        imem_ack = 1'b0; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_fetch("ldst", 1'b0, 16'h0012, 1'b1, 3'd3);
            chk("ldst.icount", icount, 16'h0005);
        end
        stall = 1'b0;
        step();
        chk_fetch("ldrel", 1'b1, 16'h0014, 1'b0, 3'd1);
        chk("ldrel.icount", icount, 16'h0006);

        // CBZ -11 words from 0x0014 wraps to 0xFFFE.
        imem_ack = 1'b1; imem_rdata = 16'hBD40;
        step();
        imem_ack = 1'b0; branch = 1'b1; zero = 1'b1;
        step();
        chk_fetch("toFFFE", 1'b1, 16'hFFFE, 1'b0, 3'd1);

        // ADD at 0xFFFE, run=0 in EXEC: wraps to 0 and goes idle.
        branch = 1'b0; zero = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h0000;
        step();
        chk_fetch("addF", 1'b0, 16'hFFFE, 1'b1, 3'd0);
        imem_ack = 1'b0; run = 1'b0;
        step();
        chk_fetch("idle", 1'b0, 16'h0000, 1'b0, 3'd1);
        chk("idle.icount", icount, 16'h0008);
        imem_ack = 1'b1; imem_rdata = 16'hFFFF;  // stray ack in IDLE
        step();
        chk_fetch("idleack", 1'b0, 16'h0000, 1'b0, 3'd1);
        chk("idleack.instr", instr, 16'h0000);

        // Refetch to pc=2, then reset while the request is pending.
        imem_ack = 1'b0; run = 1'b1;
        step();
        imem_ack = 1'b1; imem_rdata = 16'h0000;
        step();
        imem_ack = 1'b0;
        step();
        chk_fetch("pre", 1'b1, 16'h0002, 1'b0, 3'd1);
        chk("pre.icount", icount, 16'h0009);
        reset = 1'b1;
        step();
        chk_fetch("mrst", 1'b0, 16'h0000, 1'b0, 3'd1);
        chk("mrst.icount", icount, 16'h0000);
        reset = 1'b0; run = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hFFFF;
        step();
        chk_fetch("late", 1'b0, 16'h0000, 1'b0, 3'd1);
        chk("late.instr",  instr,  16'h0000);
        chk("late.icount", icount, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/leglite_ifetch.md
Name: leglite_ifetch

Overview:
- Instruction fetch/sequencer for the LEGLite single-issue core; the producer of the 3-bit opcode that the LEGLite control decoder consumes.
- Owns the PC and runs a request/acknowledge handshake to instruction memory.
- Holds the fetched 16-bit instruction for execution and presents opcode/instr to the control and datapath.
- Takes branch (from control) and zero (from ALU) back to select the next PC.

Parameters:
- RESET_PC, 16'h0000, byte address loaded into the PC on reset.
- NOP_OPCODE, 3'd1, opcode driven whenever no instruction is executing; decodes to all control signals deasserted.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  level; enables fetching.
- imem_addr  output  16  byte address of the requested instruction.
- imem_req  output  1  fetch request.
- imem_ack  input  1  memory has imem_rdata valid this cycle.
- imem_rdata  input  16  instruction word.
- opcode  output  3  instr[15:13] in EXEC, otherwise NOP_OPCODE.
- instr  output  16  held instruction register.
- instr_valid  output  1  high during every EXEC cycle.
- stall  input  1  datapath extends EXEC.
- branch  input  1  control branch signal for the current opcode.
- zero  input  1  ALU zero flag for the current instruction.
- pc  output  16  address of the instruction in EXEC / being fetched.
- icount  output  16  count of retired instructions.

Behaviour:
- Reset (synchronous, active-high; wins over all other inputs) sets:
  - state to IDLE, pc to RESET_PC, instr to 0, icount to 0.
  - imem_req, instr_valid to 0; opcode to NOP_OPCODE.
  - Reset in any state, including mid-request, drops imem_req the following cycle; a late imem_ack is ignored.
- States:
  - IDLE: imem_req=0. Moves to REQ the cycle after run=1 is seen.
  - REQ:
    - imem_req=1 and imem_addr=pc; both stay stable until ack.
    - On imem_ack=1: capture instr<=imem_rdata and go to EXEC.
    - imem_ack=0 keeps REQ indefinitely; there is no timeout.
    - imem_ack outside REQ is ignored.
    - Deasserting run while in REQ does not abort the request.
  - EXEC:
    - imem_req=0, instr_valid=1, opcode=instr[15:13].
    - If stall=1, remain in EXEC with pc and instr held.
    - If stall=0, the instruction retires this cycle:
      - icount<=icount+1, wrapping at 16'hFFFF->0.
      - pc<=next_pc.
      - Go to REQ if run=1, else IDLE.
- next_pc:
  - taken = branch & zero, sampled in the retiring cycle only.
  - off = instr[12:6], a 7-bit signed word offset.
  - taken: pc + (sign_extend(off)<<1).
  - not taken: pc + 2.
  - Arithmetic is modulo 2^16; wrap-around is legal, e.g. pc 16'hFFFE + 2 -> 16'h0000.
  - off=0 taken is a legal self-loop.
- pc[0] is always 0.
- Latency:
  - Minimum 2 cycles per instruction: 1 REQ cycle with same-cycle ack, plus 1 EXEC cycle.
  - First imem_req rises 1 cycle after run is sampled high in IDLE.
- Outputs are registered or decoded only from state and instr; there are no combinational paths from imem_ack or imem_rdata to any output.

Decomposition:
- Shared leglite package holds:
  - the opcode constants (ADD=0, LD=3, ST=4, CBZ=5, ADDI=6, ANDI=7, NOP=1);
  - field positions: OPC_MSB=15, OPC_LSB=13, BOFF_MSB=12, BOFF_LSB=6;
  - the state encoding (IDLE, REQ, EXEC).
- One natural sub-module, leglite_next_pc: purely combinational sign-extend, shift, add and select, reusable by the verification model.

Test Plan:
- Reset then run=1, memory acks the same cycle with 16'h0000 (ADD): imem_req at cycle 1 with addr 0; EXEC at cycle 2 with opcode=0; next request addr=2; icount=1.
- Memory delays ack 3 cycles: imem_req and imem_addr held stable for 3 cycles; instr_valid stays low until the ack; no EXEC entered early.
- CBZ 16'hA000|(7'h7E<<6) at pc=16'h0010 with branch=1, zero=1: next imem_addr=16'h000C. Same instruction with zero=0: next imem_addr=16'h0012.
- stall=1 for 2 cycles in EXEC on LD: opcode=3 held for 3 cycles; icount increments once; pc unchanged until the release cycle.
- pc=16'hFFFE not taken: next addr 16'h0000. run=0 during EXEC: returns to IDLE, opcode=1, imem_req=0.
- reset asserted in REQ while ack is pending: next cycle imem_req=0, pc=RESET_PC, icount=0; an ack arriving after reset changes nothing.
